evr_seconds_decoder: RTL and testbench

//   EVR-domain source of the PPS-marker / seconds interface consumed by the Aurora-domain timestamp generator.

---
 rtl/evr_event_pkg.sv | 14 +
 rtl/evr_marker_stretcher.sv | 56 +++++
 rtl/evr_seconds_decoder.sv | 124 ++++++++++++
 tb/tb_evr_seconds_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/evr_event_pkg.sv
// rtl/evr_event_pkg.sv - MRF event codes and marker stretcher state encoding
package evr_event_pkg;

  localparam logic [7:0] CODE_SHIFT0 = 8'h70;
  localparam logic [7:0] CODE_SHIFT1 = 8'h71;
  localparam logic [7:0] CODE_MARKER = 8'h7D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HOLD = 2'd2
  } stretch_state_e;

endpackage

// File: rtl/evr_marker_stretcher.sv
// rtl/evr_marker_stretcher.sv - one-cycle arm then fixed-width marker pulse
module evr_marker_stretcher
  import evr_event_pkg::*;
#(
  parameter int STRETCH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger_i,
  output logic marker_o,
  output logic busy_o
);

  localparam int CW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(STRETCH - 1);

  stretch_state_e  state_q;
  logic [CW-1:0]   cnt_q;
  logic            marker_q;

  // ARM gives the committed seconds one full cycle to settle before the marker rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      marker_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger_i) state_q <= ST_ARM;
        end
        ST_ARM: begin
          state_q  <= ST_HOLD;
          marker_q <= 1'b1;
          cnt_q    <= '0;
        end
        ST_HOLD: begin
          if (cnt_q == LAST) begin
            state_q  <= ST_IDLE;
            marker_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          marker_q <= 1'b0;
        end
      endcase
    end
  end

  assign marker_o = marker_q;
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: rtl/evr_seconds_decoder.sv
// rtl/evr_seconds_decoder.sv - event stream to seconds value, stretched PPS marker and marker health
module evr_seconds_decoder
  import evr_event_pkg::*;
#(
  parameter int         SECONDS_WIDTH  = 32,
  parameter logic [7:0] CODE_SHIFT0    = evr_event_pkg::CODE_SHIFT0,
  parameter logic [7:0] CODE_SHIFT1    = evr_event_pkg::CODE_SHIFT1,
  parameter logic [7:0] CODE_MARKER    = evr_event_pkg::CODE_MARKER,
  parameter int         MARKER_STRETCH = 8,
  parameter int         CLOCK_RATE     = 125000000,
  parameter int         TIMEOUT_TICKS  = CLOCK_RATE + CLOCK_RATE / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               evrCode,
  input  logic                     evrCodeValid,
  output logic                     evrPPSmarker,
  output logic [SECONDS_WIDTH-1:0] evrSeconds,
  output logic                     secondsValid,
  output logic                     ppsValid,
  output logic [15:0]              shiftErrorCount
);

  localparam int W   = SECONDS_WIDTH;
  localparam int CW  = $clog2(W + 2);
  localparam int WDW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(W);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(W + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_TICKS);

  logic [W-1:0]   shift_reg_q, shift_reg_d;
  logic [CW-1:0]  shift_cnt_q, shift_cnt_d;
  logic [W-1:0]   seconds_q, seconds_d;
  logic           sec_valid_q, sec_valid_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           pps_valid_q, pps_valid_d;
  logic           seen_marker_q, seen_marker_d;

  logic is_shift, is_marker, busy, accept, good_commit, count_error;

  assign is_shift    = evrCodeValid && ((evrCode == CODE_SHIFT0) || (evrCode == CODE_SHIFT1));
  assign is_marker   = evrCodeValid && (evrCode == CODE_MARKER);
  assign accept      = is_marker && !busy;
  assign good_commit = (shift_cnt_q == CNT_FULL);
  assign count_error = is_marker && (busy || !good_commit);

  always_comb begin
    shift_reg_d   = shift_reg_q;
    shift_cnt_d   = shift_cnt_q;
    seconds_d     = seconds_q;
    sec_valid_d   = sec_valid_q;
    err_cnt_d     = err_cnt_q;
    wd_d          = wd_q;
    pps_valid_d   = pps_valid_q;
    seen_marker_d = seen_marker_q;

    if (is_shift) begin
      shift_reg_d = {shift_reg_q[W-2:0], (evrCode == CODE_SHIFT1)};
      if (shift_cnt_q != CNT_SAT) shift_cnt_d = shift_cnt_q + CW'(1);
    end

    if (accept) begin
      shift_cnt_d = '0;
      if (good_commit) begin
        seconds_d   = shift_reg_q;
        sec_valid_d = 1'b1;
      end else begin
        // free-run so downstream still sees monotonic seconds on a corrupted sequence
        seconds_d   = seconds_q + W'(1);
        sec_valid_d = 1'b0;
      end
      if (seen_marker_q && (wd_q < WD_LIMIT)) pps_valid_d = 1'b1;
      seen_marker_d = 1'b1;
      wd_d          = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + WDW'(1);
      if (wd_q == WD_LIMIT - WDW'(1)) begin
        pps_valid_d   = 1'b0;
        seen_marker_d = 1'b0;
      end
    end

    if (count_error && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg_q   <= '0;
      shift_cnt_q   <= '0;
      seconds_q     <= '0;
      sec_valid_q   <= 1'b0;
      err_cnt_q     <= '0;
      wd_q          <= '0;
      pps_valid_q   <= 1'b0;
      seen_marker_q <= 1'b0;
    end else begin
      shift_reg_q   <= shift_reg_d;
      shift_cnt_q   <= shift_cnt_d;
      seconds_q     <= seconds_d;
      sec_valid_q   <= sec_valid_d;
      err_cnt_q     <= err_cnt_d;
      wd_q          <= wd_d;
      pps_valid_q   <= pps_valid_d;
      seen_marker_q <= seen_marker_d;
    end
  end

  evr_marker_stretcher #(
    .STRETCH (MARKER_STRETCH)
  ) u_stretcher (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger_i (accept),
    .marker_o  (evrPPSmarker),
    .busy_o    (busy)
  );

  assign evrSeconds      = seconds_q;
  assign secondsValid    = sec_valid_q;
  assign ppsValid        = pps_valid_q;
  assign shiftErrorCount = err_cnt_q;

endmodule

// File: tb/tb_evr_seconds_decoder.sv
// tb/tb_evr_seconds_decoder.sv - directed checks of commit timing, marker width, watchdog and error saturation
module tb_evr_seconds_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  evrCode;
  logic        evrCodeValid;
  logic        evrPPSmarker;
  logic [31:0] evrSeconds;
  logic        secondsValid;
  logic        ppsValid;
  logic [15:0] shiftErrorCount;

  int total = 0;
  int bad   = 0;
  int hi;

  always #5 clk = ~clk;

  evr_seconds_decoder #(
    .TIMEOUT_TICKS (1000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .evrCode         (evrCode),
    .evrCodeValid    (evrCodeValid),
    .evrPPSmarker    (evrPPSmarker),
    .evrSeconds      (evrSeconds),
    .secondsValid    (secondsValid),
    .ppsValid        (ppsValid),
    .shiftErrorCount (shiftErrorCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the following rising edge consumes them.
  task automatic put(input logic [7:0] code);
    @(negedge clk);
    evrCode      = code;
    evrCodeValid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    evrCodeValid = 1'b0;
  endtask

  task automatic shift_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) put(v[i] ? 8'h71 : 8'h70);
  endtask

  initial begin
    rst_n        = 1'b0;
    evrCode      = 8'h00;
    evrCodeValid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_marker", 32'(evrPPSmarker), 32'd0);
    check("rst_seconds", evrSeconds, 32'd0);
    check("rst_secvalid", 32'(secondsValid), 32'd0);
    check("rst_ppsvalid", 32'(ppsValid), 32'd0);
    check("rst_errcnt", 32'(shiftErrorCount), 32'd0);
    rst_n = 1'b1;

    // full 32-bit sequence then marker
    shift_word(32'h12345678, 32);
    put(8'h7D);
    idle();
    check("t1_seconds_n1", evrSeconds, 32'h12345678);
    check("t1_secvalid", 32'(secondsValid), 32'd1);
    check("t1_marker_n1_low", 32'(evrPPSmarker), 32'd0);
    check("t1_pps_first", 32'(ppsValid), 32'd0);
    for (int k = 2; k <= 9; k++) begin
      idle();
      check("t1_marker_high", 32'(evrPPSmarker), 32'd1);
    end
    idle();
    check("t1_marker_n10_low", 32'(evrPPSmarker), 32'd0);
    check("t1_errcnt", 32'(shiftErrorCount), 32'd0);

    // load all-ones, then a short (31-bit) sequence wraps seconds to 0
    shift_word(32'hFFFFFFFF, 32);
    put(8'h7D);
    repeat (10) idle();
    check("t2_seconds_ones", evrSeconds, 32'hFFFFFFFF);
    check("t2_pps_second", 32'(ppsValid), 32'd1);
    shift_word(32'h0, 31);
    put(8'h7D);
    idle();
    check("t2_seconds_wrap", evrSeconds, 32'd0);
    check("t2_secvalid", 32'(secondsValid), 32'd0);
    check("t2_errcnt", 32'(shiftErrorCount), 32'd1);
    repeat (9) idle();

    // marker 4 cycles after an accepted one is ignored
    shift_word(32'hA5A50F0F, 32);
    put(8'h7D);
    hi = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) put(8'h7D);
      else idle();
      hi += int'(evrPPSmarker);
    end
    check("t3_marker_width", 32'(hi), 32'd8);
    check("t3_errcnt", 32'(shiftErrorCount), 32'd2);
    check("t3_seconds", evrSeconds, 32'hA5A50F0F);
    check("t3_secvalid", 32'(secondsValid), 32'd1);

    // unqualified marker and foreign codes change nothing
    @(negedge clk);
    evrCode      = 8'h7D;
    evrCodeValid = 1'b0;
    put(8'h72);
    put(8'h00);
    idle();
    idle();
    check("t3_noeffect_seconds", evrSeconds, 32'hA5A50F0F);
    check("t3_noeffect_marker", 32'(evrPPSmarker), 32'd0);
    check("t3_noeffect_errcnt", 32'(shiftErrorCount), 32'd2);

    // watchdog with a 1000-cycle limit, markers every 900
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    put(8'h7D);
    idle();
    check("t4_pps_first", 32'(ppsValid), 32'd0);
    repeat (898) idle();
    put(8'h7D);
    idle();
    check("t4_pps_second", 32'(ppsValid), 32'd1);
    repeat (898) idle();
    put(8'h7D);
    idle();
    check("t4_pps_third", 32'(ppsValid), 32'd1);
    repeat (998) idle();
    idle();
    check("t4_pps_before_timeout", 32'(ppsValid), 32'd1);
    idle();
    check("t4_pps_timeout", 32'(ppsValid), 32'd0);
    check("t4_errcnt", 32'(shiftErrorCount), 32'd3);
    put(8'h7D);
    idle();
    check("t4_pps_after_timeout", 32'(ppsValid), 32'd0);
    repeat (898) idle();
    put(8'h7D);
    idle();
    check("t4_pps_recovered", 32'(ppsValid), 32'd1);
    repeat (10) idle();

    // reset in the middle of HOLD
    shift_word(32'h000000FF, 32);
    put(8'h7D);
    repeat (3) idle();
    check("t5_marker_hold", 32'(evrPPSmarker), 32'd1);
    check("t5_pps_hold", 32'(ppsValid), 32'd1);
    check("t5_seconds_hold", evrSeconds, 32'h000000FF);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_marker", 32'(evrPPSmarker), 32'd0);
    check("t5_rst_seconds", evrSeconds, 32'd0);
    check("t5_rst_secvalid", 32'(secondsValid), 32'd0);
    check("t5_rst_ppsvalid", 32'(ppsValid), 32'd0);
    check("t5_rst_errcnt", 32'(shiftErrorCount), 32'd0);
    rst_n = 1'b1;

    // every marker cycle is either a bad commit or an ignored marker
    repeat (65534) put(8'h7D);
    idle();
    check("t6_errcnt_fffe", 32'(shiftErrorCount), 32'h0000FFFE);
    repeat (2000) put(8'h7D);
    idle();
    check("t6_errcnt_sat", 32'(shiftErrorCount), 32'h0000FFFF);
    check("t6_secvalid", 32'(secondsValid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
